regfile_write_buffer: RTL and testbench

- Buffers register writeback requests from the execute/load stages and drains them into the 32 x 64-bit register file's single write port (rd, Reg_Write, Write_Data), one write per cycle.
- Also serves forwarding lookups: for rs1/rs2 it returns the youngest pending value not yet committed to the register file.
- Sits between the writeback producers and registerFile; it is the write-side master of that port.

---
 rtl/regfile_pkg.sv | 14 +
 rtl/wb_fifo.sv | 77 +++++++
 rtl/regfile_write_buffer.sv | 105 ++++++++++
 tb/tb_regfile_write_buffer.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types and constants for the register-file writeback path.
package regfile_pkg;

  localparam int XLEN = 64;
  localparam int AW = 5;
  localparam int NUM_REGS = 32;
  localparam logic [AW-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic [AW-1:0]   rd;
    logic [XLEN-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Generic register FIFO with occupancy count; exposes storage and per-slot
// valid bits so a parent can search pending entries.
module wb_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 69,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      push,
  input  logic                      pop,
  input  logic [W-1:0]              din,
  output logic [W-1:0]              dout,
  output logic [CW-1:0]             count,
  output logic [PW-1:0]             head,
  output logic [DEPTH-1:0][W-1:0]   entries,
  output logic [DEPTH-1:0]          valid
);

  logic [DEPTH-1:0][W-1:0] mem_r;
  logic [PW-1:0]           wr_ptr_r;
  logic [PW-1:0]           rd_ptr_r;
  logic [CW-1:0]           count_r;
  logic [DEPTH-1:0]        valid_r;
  logic                    do_push_s;
  logic                    do_pop_s;
  logic [DEPTH-1:0]        push_mask_s;
  logic [DEPTH-1:0]        pop_mask_s;

  // Full/empty come from the count, never from pointer equality.
  assign do_push_s = push && (count_r < CW'(DEPTH));
  assign do_pop_s  = pop && (count_r != '0);

  // One-hot slot masks for the valid-bit update.
  always_comb begin
    push_mask_s = '0;
    pop_mask_s  = '0;
    if (do_push_s) begin
      push_mask_s[wr_ptr_r] = 1'b1;
    end else begin
      push_mask_s = '0;
    end
    if (do_pop_s) begin
      pop_mask_s[rd_ptr_r] = 1'b1;
    end else begin
      pop_mask_s = '0;
    end
  end

  // Pointers, occupancy and valid bits; pointers wrap modulo DEPTH.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      valid_r  <= '0;
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + PW'(1);
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + PW'(1);
      count_r <= count_r + CW'(do_push_s) - CW'(do_pop_s);
      valid_r <= (valid_r & ~pop_mask_s) | push_mask_s;
    end
  end

  // Entry storage; slots are qualified by valid_r so no data reset is needed.
  always_ff @(posedge clk) begin
    if (do_push_s) mem_r[wr_ptr_r] <= din;
  end

  assign dout    = mem_r[rd_ptr_r];
  assign count   = count_r;
  assign head    = rd_ptr_r;
  assign entries = mem_r;
  assign valid   = valid_r;

endmodule

// File: rtl/regfile_write_buffer.sv
// Writeback buffer in front of the register file write port, with
// youngest-first forwarding of values not yet committed.
module regfile_write_buffer
  import regfile_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int XLEN = regfile_pkg::XLEN,
  parameter int AW = regfile_pkg::AW
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [AW-1:0]              in_rd,
  input  logic [XLEN-1:0]            in_data,
  input  logic [AW-1:0]              rs1,
  input  logic [AW-1:0]              rs2,
  output logic                       fwd1_hit,
  output logic [XLEN-1:0]            fwd1_data,
  output logic                       fwd2_hit,
  output logic [XLEN-1:0]            fwd2_data,
  output logic [AW-1:0]              rd,
  output logic                       Reg_Write,
  output logic [XLEN-1:0]            Write_Data,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = AW + XLEN;

  logic [CW-1:0]            count_s;
  logic [PW-1:0]            head_s;
  logic [DEPTH-1:0][EW-1:0] entries_s;
  logic [DEPTH-1:0]         valid_s;
  logic [EW-1:0]            head_entry_s;
  logic                     accept_s;
  logic                     push_s;
  logic                     pop_s;

  // Walk oldest to youngest so the youngest match wins; output stage ranks lowest.
  function automatic logic [XLEN:0] fwd_lookup(
    input logic [AW-1:0]              rs,
    input logic [DEPTH-1:0][EW-1:0]   ents,
    input logic [DEPTH-1:0]           vld,
    input logic [PW-1:0]              head,
    input logic                       out_v,
    input logic [AW-1:0]              out_rd,
    input logic [XLEN-1:0]            out_data
  );
    logic [XLEN:0] res;
    logic [PW-1:0] idx;
    res = '0;
    if (rs != AW'(REG_ZERO)) begin
      if (out_v && (out_rd == rs)) res = {1'b1, out_data};
      for (int i = 0; i < DEPTH; i++) begin
        idx = head + PW'(i);
        if (vld[idx] && (ents[idx][EW-1 -: AW] == rs)) res = {1'b1, ents[idx][XLEN-1:0]};
      end
    end
    return res;
  endfunction

  assign in_ready = !reset && (count_s < CW'(DEPTH));
  assign accept_s = in_valid && in_ready;
  // x0 writes complete the handshake but never enter the buffer.
  assign push_s   = accept_s && (in_rd != AW'(REG_ZERO));
  assign pop_s    = (count_s != '0);

  wb_fifo #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push_s),
    .pop     (pop_s),
    .din     ({in_rd, in_data}),
    .dout    (head_entry_s),
    .count   (count_s),
    .head    (head_s),
    .entries (entries_s),
    .valid   (valid_s)
  );

  // Output stage: one head entry per cycle onto the register file port.
  always_ff @(posedge clk) begin
    if (reset) begin
      Reg_Write  <= 1'b0;
      rd         <= '0;
      Write_Data <= '0;
    end else if (pop_s) begin
      Reg_Write  <= 1'b1;
      rd         <= head_entry_s[EW-1 -: AW];
      Write_Data <= head_entry_s[XLEN-1:0];
    end else begin
      Reg_Write  <= 1'b0;
    end
  end

  assign {fwd1_hit, fwd1_data} = fwd_lookup(rs1, entries_s, valid_s, head_s, Reg_Write, rd, Write_Data);
  assign {fwd2_hit, fwd2_data} = fwd_lookup(rs2, entries_s, valid_s, head_s, Reg_Write, rd, Write_Data);
  assign count = count_s;

endmodule

// File: tb/tb_regfile_write_buffer.sv
// Self-checking bench for regfile_write_buffer: directed vector table,
// hand-written corner sequences and randomized traffic against a queue model.
module tb_regfile_write_buffer;
  import regfile_pkg::*;

  localparam int DEPTH = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic            in_valid;
  logic            in_ready;
  logic [AW-1:0]   in_rd;
  logic [XLEN-1:0] in_data;
  logic [AW-1:0]   rs1;
  logic [AW-1:0]   rs2;
  logic            fwd1_hit;
  logic [XLEN-1:0] fwd1_data;
  logic            fwd2_hit;
  logic [XLEN-1:0] fwd2_data;
  logic [AW-1:0]   rd;
  logic            Reg_Write;
  logic [XLEN-1:0] Write_Data;
  logic [2:0]      count;

  always #5 clk = ~clk;

  regfile_write_buffer #(.DEPTH(DEPTH), .XLEN(XLEN), .AW(AW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_rd(in_rd), .in_data(in_data), .rs1(rs1), .rs2(rs2),
    .fwd1_hit(fwd1_hit), .fwd1_data(fwd1_data), .fwd2_hit(fwd2_hit), .fwd2_data(fwd2_data),
    .rd(rd), .Reg_Write(Reg_Write), .Write_Data(Write_Data), .count(count)
  );

  typedef struct {
    logic rst; logic v; logic [AW-1:0] rdi; logic [XLEN-1:0] d; logic [AW-1:0] r1; logic [AW-1:0] r2;
    logic e_ready; logic [2:0] e_count; logic e_rw; logic [AW-1:0] e_rd; logic [XLEN-1:0] e_wd;
    logic e_h1; logic [XLEN-1:0] e_d1; logic e_h2; logic [XLEN-1:0] e_d2;
  } vec_t;

  vec_t tbl[13];

  int checks = 0;
  int errors = 0;

  // Reference model: pending FIFO contents plus the register-file port.
  wb_entry_t       m_q[$];
  logic            m_v = 1'b0;
  logic [AW-1:0]   m_rd = '0;
  logic [XLEN-1:0] m_wd = '0;

  // Register file as seen through the write port, and a write-order log.
  logic [XLEN-1:0] regs [NUM_REGS];
  int              x0_writes = 0;
  bit              log_en = 1'b0;
  logic [AW-1:0]   wlog[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic void m_fwd(input logic [AW-1:0] rs, output logic hit, output logic [XLEN-1:0] data);
    hit = 1'b0;
    data = '0;
    if (rs == REG_ZERO) return;
    for (int i = m_q.size() - 1; i >= 0; i--) begin
      if (m_q[i].rd == rs) begin
        hit = 1'b1;
        data = m_q[i].data;
        return;
      end
    end
    if (m_v && (m_rd == rs)) begin
      hit = 1'b1;
      data = m_wd;
    end
  endfunction

  task automatic model_compare();
    logic h1, h2;
    logic [XLEN-1:0] d1, d2;
    m_fwd(rs1, h1, d1);
    m_fwd(rs2, h2, d2);
    chk("m_in_ready", 64'(in_ready), 64'(!reset && (m_q.size() < DEPTH)));
    chk("m_count", 64'(count), 64'(m_q.size()));
    chk("m_reg_write", 64'(Reg_Write), 64'(m_v));
    chk("m_rd", 64'(rd), 64'(m_rd));
    chk("m_write_data", Write_Data, m_wd);
    chk("m_fwd1_hit", 64'(fwd1_hit), 64'(h1));
    chk("m_fwd1_data", fwd1_data, d1);
    chk("m_fwd2_hit", 64'(fwd2_hit), 64'(h2));
    chk("m_fwd2_data", fwd2_data, d2);
  endtask

  task automatic table_compare(input int r);
    chk($sformatf("t%0d_in_ready", r), 64'(in_ready), 64'(tbl[r].e_ready));
    chk($sformatf("t%0d_count", r), 64'(count), 64'(tbl[r].e_count));
    chk($sformatf("t%0d_reg_write", r), 64'(Reg_Write), 64'(tbl[r].e_rw));
    chk($sformatf("t%0d_rd", r), 64'(rd), 64'(tbl[r].e_rd));
    chk($sformatf("t%0d_write_data", r), Write_Data, tbl[r].e_wd);
    chk($sformatf("t%0d_fwd1_hit", r), 64'(fwd1_hit), 64'(tbl[r].e_h1));
    chk($sformatf("t%0d_fwd1_data", r), fwd1_data, tbl[r].e_d1);
    chk($sformatf("t%0d_fwd2_hit", r), 64'(fwd2_hit), 64'(tbl[r].e_h2));
    chk($sformatf("t%0d_fwd2_data", r), fwd2_data, tbl[r].e_d2);
  endtask

  // One clock: check settled pre-edge outputs, commit the port write, advance the model.
  task automatic tick(input bit mchk, input int row);
    logic acc;
    wb_entry_t e;
    #1;
    if (mchk) model_compare();
    if (row >= 0) table_compare(row);
    acc = in_valid && !reset && (m_q.size() < DEPTH);
    if (Reg_Write) begin
      regs[rd] = Write_Data;
      if (rd == REG_ZERO) x0_writes++;
      if (log_en) wlog.push_back(rd);
    end
    @(posedge clk);
    if (reset) begin
      m_q.delete();
      m_v = 1'b0;
      m_rd = '0;
      m_wd = '0;
    end else begin
      if (m_q.size() > 0) begin
        e = m_q.pop_front();
        m_v = 1'b1;
        m_rd = e.rd;
        m_wd = e.data;
      end else begin
        m_v = 1'b0;
      end
      if (acc && (in_rd != REG_ZERO)) m_q.push_back('{rd: in_rd, data: in_data});
    end
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < NUM_REGS; i++) regs[i] = '0;

    //           rst   v     rdi    d         r1     r2     rdy   cnt   rw    rd     wd        h1    d1        h2    d2
    tbl[0]  = '{1'b1, 1'b0, 5'd0,  64'h0,    5'd12, 5'd3,  1'b0, 3'd0, 1'b0, 5'd0,  64'h0,    1'b0, 64'h0,    1'b0, 64'h0};
    tbl[1]  = '{1'b0, 1'b1, 5'd12, 64'h9,    5'd12, 5'd3,  1'b1, 3'd0, 1'b0, 5'd0,  64'h0,    1'b0, 64'h0,    1'b0, 64'h0};
    tbl[2]  = '{1'b0, 1'b0, 5'd0,  64'h0,    5'd12, 5'd3,  1'b1, 3'd1, 1'b0, 5'd0,  64'h0,    1'b1, 64'h9,    1'b0, 64'h0};
    tbl[3]  = '{1'b0, 1'b0, 5'd0,  64'h0,    5'd12, 5'd3,  1'b1, 3'd0, 1'b1, 5'd12, 64'h9,    1'b1, 64'h9,    1'b0, 64'h0};
    tbl[4]  = '{1'b0, 1'b0, 5'd0,  64'h0,    5'd12, 5'd3,  1'b1, 3'd0, 1'b0, 5'd12, 64'h9,    1'b0, 64'h0,    1'b0, 64'h0};
    tbl[5]  = '{1'b0, 1'b1, 5'd0,  64'hFFFF, 5'd0,  5'd3,  1'b1, 3'd0, 1'b0, 5'd12, 64'h9,    1'b0, 64'h0,    1'b0, 64'h0};
    tbl[6]  = '{1'b0, 1'b0, 5'd0,  64'h0,    5'd0,  5'd3,  1'b1, 3'd0, 1'b0, 5'd12, 64'h9,    1'b0, 64'h0,    1'b0, 64'h0};
    tbl[7]  = '{1'b0, 1'b0, 5'd0,  64'h0,    5'd0,  5'd0,  1'b1, 3'd0, 1'b0, 5'd12, 64'h9,    1'b0, 64'h0,    1'b0, 64'h0};
    tbl[8]  = '{1'b0, 1'b1, 5'd7,  64'hA,    5'd7,  5'd3,  1'b1, 3'd0, 1'b0, 5'd12, 64'h9,    1'b0, 64'h0,    1'b0, 64'h0};
    tbl[9]  = '{1'b0, 1'b1, 5'd7,  64'hB,    5'd7,  5'd3,  1'b1, 3'd1, 1'b0, 5'd12, 64'h9,    1'b1, 64'hA,    1'b0, 64'h0};
    tbl[10] = '{1'b0, 1'b0, 5'd0,  64'h0,    5'd7,  5'd3,  1'b1, 3'd1, 1'b1, 5'd7,  64'hA,    1'b1, 64'hB,    1'b0, 64'h0};
    tbl[11] = '{1'b0, 1'b0, 5'd0,  64'h0,    5'd7,  5'd3,  1'b1, 3'd0, 1'b1, 5'd7,  64'hB,    1'b1, 64'hB,    1'b0, 64'h0};
    tbl[12] = '{1'b0, 1'b0, 5'd0,  64'h0,    5'd7,  5'd3,  1'b1, 3'd0, 1'b0, 5'd7,  64'hB,    1'b0, 64'h0,    1'b0, 64'h0};

    reset = 1'b1; in_valid = 1'b0; in_rd = '0; in_data = '0; rs1 = '0; rs2 = '0;
    repeat (4) tick(1'b0, -1);

    // Directed table: reset, single write, x0 discard, forwarding priority.
    for (int r = 0; r < 13; r++) begin
      reset = tbl[r].rst; in_valid = tbl[r].v; in_rd = tbl[r].rdi; in_data = tbl[r].d;
      rs1 = tbl[r].r1; rs2 = tbl[r].r2;
      tick(1'b0, r);
    end
    chk("regfile_r12", regs[12], 64'h9);
    chk("regfile_r7", regs[7], 64'hB);
    chk("x0_writes", 64'(x0_writes), 64'h0);

    // Back-to-back pushes rd 1..5: occupancy bounded, drain order preserved.
    wlog.delete(); log_en = 1'b1; rs1 = 5'd3; rs2 = 5'd5;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_rd = AW'(i + 1); in_data = 64'h10 + 64'(i);
      tick(1'b1, -1);
      chk("fill_count_le_depth", 64'(count <= 3'(DEPTH)), 64'h1);
    end
    in_valid = 1'b0;
    repeat (3) tick(1'b1, -1);
    chk("fill_log_size", 64'(wlog.size()), 64'd5);
    for (int i = 0; i < 5 && i < wlog.size(); i++) chk("fill_order", 64'(wlog[i]), 64'(i + 1));

    // Streaming ten requests: steady count of 1 and pointers wrap twice.
    wlog.delete();
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; in_rd = AW'(i + 1); in_data = 64'h100 + 64'(i);
      rs1 = AW'(i); rs2 = AW'(i + 1);
      tick(1'b1, -1);
      if (i > 0) chk("stream_count", 64'(count), 64'd1);
    end
    in_valid = 1'b0;
    repeat (3) tick(1'b1, -1);
    chk("stream_log_size", 64'(wlog.size()), 64'd10);
    for (int i = 0; i < 10 && i < wlog.size(); i++) chk("stream_order", 64'(wlog[i]), 64'(i + 1));
    log_en = 1'b0;

    // Reset in the middle of traffic discards everything pending.
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_rd = AW'(20 + i); in_data = 64'h200 + 64'(i);
      tick(1'b1, -1);
    end
    in_valid = 1'b0; reset = 1'b1;
    tick(1'b1, -1);
    reset = 1'b0; rs1 = 5'd22; rs2 = 5'd21;
    #1;
    chk("midrst_count", 64'(count), 64'd0);
    chk("midrst_reg_write", 64'(Reg_Write), 64'd0);
    chk("midrst_rd", 64'(rd), 64'd0);
    chk("midrst_write_data", Write_Data, 64'd0);
    chk("midrst_fwd1_hit", 64'(fwd1_hit), 64'd0);
    chk("midrst_fwd2_hit", 64'(fwd2_hit), 64'd0);
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, -1);
      chk("midrst_no_write", 64'(Reg_Write), 64'd0);
    end

    // Randomized traffic with a narrow rd range to force address collisions.
    for (int n = 0; n < 400; n++) begin
      reset    = ($urandom_range(0, 49) == 0);
      in_valid = ($urandom_range(0, 3) != 0);
      in_rd    = AW'($urandom_range(0, 7));
      in_data  = {$urandom, $urandom};
      rs1      = AW'($urandom_range(0, 7));
      rs2      = AW'($urandom_range(0, 7));
      tick(1'b1, -1);
    end
    reset = 1'b0; in_valid = 1'b0;
    repeat (3) tick(1'b1, -1);
    chk("x0_writes_final", 64'(x0_writes), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
